operand_sequencer: RTL

- Upstream front-end for the 4-bit rotate/ALU stage. Sequences a single 4-bit data bus (switches) into operand A, then operand B, using a load strobe (button).
- Presents both operands with a valid flag to the combinational stage downstream.
- Registers that stage's 8-bit result and flags it valid.
- One clock domain; drives board-level LEDs/display.

---
 rtl/operand_sequencer_pkg.sv | 31 +++
 rtl/operand_sequencer_load_debounce.sv | 48 ++++
 rtl/operand_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/operand_sequencer_pkg.sv
// Purpose: shared types and constants for the operand sequencer and its LED/display decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package operand_sequencer_pkg;

    // Default operand and result widths for the rotate/ALU front-end.
    localparam int OPSEQ_DW = 4;
    localparam int OPSEQ_RW = 8;

    // FSM encoding; the LED/display decoder relies on these exact values.
    typedef enum logic [1:0] {
        GET_A = 2'd0,
        GET_B = 2'd1,
        EXEC  = 2'd2,
        DONE  = 2'd3
    } opseq_state_e;

    // Per-cycle datapath strobes produced by the sequencing FSM.
    typedef struct packed {
        logic cap_a;    // sample din into op_a
        logic cap_b;    // sample din into op_b
        logic cap_res;  // sample result_in into result_q
        logic zero;     // abort: wipe operands and result
    } opseq_ctrl_t;

    // Both operands are stable and presented downstream in these states.
    function automatic logic state_has_ops(input opseq_state_e s);
        return (s == EXEC) || (s == DONE);
    endfunction

endpackage

// File: rtl/operand_sequencer_load_debounce.sv
// Purpose: 2-flop synchroniser plus stable-count filter for the load button.
// Latency: load_f follows a sustained change of load after 2 + DEBOUNCE_CYCLES cycles.
// Backpressure: none; free-running filter, shorter glitches are discarded.
module operand_sequencer_load_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic load_f
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] stable_cnt;

    // Bring the asynchronous button into the clk domain; reset high so a
    // button held through reset does not look like a fresh press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= load;
            sync_2 <= sync_1;
        end
    end

    // Accept a new level only after it has disagreed with load_f for
    // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_f     <= 1'b1;
            stable_cnt <= '0;
        end else if (sync_2 == load_f) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CNT_LAST) begin
            load_f     <= sync_2;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/operand_sequencer.sv
// Purpose: sequences one shared bus into op_a then op_b on load edges, registers downstream result (OPSEQ_DEBOUNCE_EN adds a load debouncer).
// Latency: op_b/op_valid register on the capturing edge, result_q/res_valid one edge later; debounce adds 2+DEBOUNCE_CYCLES.
// Backpressure: none; load rises outside GET_A/GET_B/DONE are dropped, clear aborts at any time.
module operand_sequencer
    import operand_sequencer_pkg::*;
#(
    parameter int DW              = OPSEQ_DW,
    parameter int RW              = OPSEQ_RW,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          load,
    input  logic          clear,
    input  logic [RW-1:0] result_in,
    output logic [DW-1:0] op_a,
    output logic [DW-1:0] op_b,
    output logic          op_valid,
    output logic [RW-1:0] result_q,
    output logic          res_valid,
    output logic [1:0]    state_o
);

    // The filter cannot work with fewer than two stable cycles.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce_cfg
        $error("operand_sequencer: DEBOUNCE_CYCLES must be >= 2");
    end

    logic         load_f;
    logic         load_d;
    logic         load_rise;
    opseq_state_e state_q;
    opseq_state_e state_d;
    opseq_ctrl_t  ctrl;

`ifdef OPSEQ_DEBOUNCE_EN
    operand_sequencer_load_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_load_debounce (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .load_f(load_f)
    );
`else
    // Button is already clean and synchronous to clk in this build.
    assign load_f = load;
`endif

    // Delayed copy for edge detection; reset high so a held load is not a rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_d <= 1'b1;
        end else begin
            load_d <= load_f;
        end
    end

    assign load_rise = load_f & ~load_d;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= GET_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath strobes; clear outranks any load edge.
    always_comb begin
        state_d = state_q;
        ctrl    = '0;
        if (clear) begin
            state_d   = GET_A;
            ctrl.zero = 1'b1;
        end else begin
            case (state_q)
                GET_A: begin
                    if (load_rise) begin
                        ctrl.cap_a = 1'b1;
                        state_d    = GET_B;
                    end
                end
                GET_B: begin
                    if (load_rise) begin
                        ctrl.cap_b = 1'b1;
                        state_d    = EXEC;
                    end
                end
                EXEC: begin
                    // Single cycle: the downstream result is settled on op_a/op_b now.
                    ctrl.cap_res = 1'b1;
                    state_d      = DONE;
                end
                DONE: begin
                    // Start the next operation; op_b is kept as the new default.
                    if (load_rise) begin
                        ctrl.cap_a = 1'b1;
                        state_d    = GET_B;
                    end
                end
                default: begin
                    state_d = GET_A;
                end
            endcase
        end
    end

    // Operand/result capture and registered valid flags derived from next state.
    always_ff @(posedge clk) begin
        if (rst || ctrl.zero) begin
            op_a      <= '0;
            op_b      <= '0;
            result_q  <= '0;
            op_valid  <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            if (ctrl.cap_a) begin
                op_a <= din;
            end
            if (ctrl.cap_b) begin
                op_b <= din;
            end
            if (ctrl.cap_res) begin
                result_q <= result_in;
            end
            op_valid  <= state_has_ops(state_d);
            res_valid <= (state_d == DONE);
        end
    end

    assign state_o = state_q;

endmodule
